// File: rtl/ed2platform_pio_pkg.sv
// Shared register map and helpers for the ED2 platform edge-interrupt PIO.
package ed2platform_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

  // Word with the low 'width' bits set; keeps unused read bits at zero.
  function automatic logic [31:0] low_mask(input int unsigned width);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ed2platform_pio_debounce_bit.sv
// One input channel: synchroniser, debounce counter, filtered state and
// single-cycle rise/fall pulses coincident with the filtered-state update.
module ed2platform_pio_debounce_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_i,
  input  logic [CNT_W-1:0] deb_i,
  output logic             stable_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_s;
  logic                   upd;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign upd    = (sync_s != stable_q) && (cnt_q >= deb_i);
  assign rise_o = upd & sync_s;
  assign fall_o = upd & ~sync_s;
  assign stable_o = stable_q;

  // Synchroniser chain for the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  // Debounce: accept the new level once it has disagreed for D+1 cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= deb_i) begin
      stable_d = sync_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ed2platform_pio_edge_intr.sv
// Avalon-MM input port with per-bit debounce, edge capture (W1C) and
// maskable level-sensitive interrupt.
module ed2platform_pio_edge_intr
  import ed2platform_pio_pkg::*;
#(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter int unsigned       CNT_W        = 16,
  parameter logic [CNT_W-1:0]  DEB_DEFAULT  = '0,
  parameter logic [WIDTH-1:0]  RISE_DEFAULT = '0,
  parameter logic [WIDTH-1:0]  FALL_DEFAULT = '1,
  parameter logic [WIDTH-1:0]  IN_RESET     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [31:0] BIT_MASK = low_mask(WIDTH);
  localparam logic [31:0] DEB_MASK = low_mask(CNT_W);

  logic             wr_en;
  logic [WIDTH-1:0] stable, rise_ev, fall_ev;
  logic [WIDTH-1:0] rise_en_q, mask_q, fall_en_q;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] deb_q;
  logic [31:0]      rd_d, readdata_q;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    ed2platform_pio_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .RESET_VAL  (IN_RESET[g])
    ) u_deb (
      .clk_i   (clk),
      .rst_i   (reset),
      .in_i    (in_port[g]),
      .deb_i   (deb_q),
      .stable_o(stable[g]),
      .rise_o  (rise_ev[g]),
      .fall_o  (fall_ev[g])
    );
  end

  // Edge capture: clear first, then OR in new events so a same-cycle set wins.
  always_comb begin
    cap_d = cap_q;
    if (wr_en && address == ADDR_EDGE_CAP) cap_d = cap_d & ~writedata[WIDTH-1:0];
    cap_d = cap_d | (rise_ev & rise_en_q) | (fall_ev & fall_en_q);
  end

  // Register file and capture state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en_q <= RISE_DEFAULT;
      mask_q    <= '0;
      fall_en_q <= FALL_DEFAULT;
      deb_q     <= DEB_DEFAULT;
      cap_q     <= '0;
    end else begin
      cap_q <= cap_d;
      if (wr_en) begin
        case (address)
          ADDR_RISE_EN:  rise_en_q <= writedata[WIDTH-1:0];
          ADDR_IRQ_MASK: mask_q    <= writedata[WIDTH-1:0];
          ADDR_FALL_EN:  fall_en_q <= writedata[WIDTH-1:0];
          ADDR_DEBOUNCE: deb_q     <= writedata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:     rd_d = 32'(stable)    & BIT_MASK;
      ADDR_RISE_EN:  rd_d = 32'(rise_en_q) & BIT_MASK;
      ADDR_IRQ_MASK: rd_d = 32'(mask_q)    & BIT_MASK;
      ADDR_EDGE_CAP: rd_d = 32'(cap_q)     & BIT_MASK;
      ADDR_FALL_EN:  rd_d = 32'(fall_en_q) & BIT_MASK;
      ADDR_DEBOUNCE: rd_d = 32'(deb_q)     & DEB_MASK;
      default:       rd_d = '0;
    endcase
  end

  // Registered read data, one-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= rd_d;
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_ed2platform_pio_edge_intr.sv
// Scoreboarded bench for ed2platform_pio_edge_intr (WIDTH=8, SYNC_STAGES=2).
module tb_ed2platform_pio_edge_intr;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  ed2platform_pio_edge_intr #(
    .WIDTH       (W),
    .SYNC_STAGES (2),
    .CNT_W       (16),
    .DEB_DEFAULT (16'h0000),
    .RISE_DEFAULT(8'h00),
    .FALL_DEFAULT(8'hFF),
    .IN_RESET    (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Issue a read, queue its expectation, collect the registered response.
  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    sb.push_back('{name: nm, exp: e});
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    obs_q.push_back(readdata);
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    sb_t s; logic [31:0] o;
    reset = 1'b1; in_port = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    cyc(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: irq=%b expected 0", irq); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: readdata=%h expected 0", readdata); end
    reset = 1'b0;
    cyc(1);
    rd(3'd0, 32'h00, "rst_data");
    rd(3'd1, 32'h00, "rst_rise");
    rd(3'd2, 32'h00, "rst_mask");
    rd(3'd3, 32'h00, "rst_cap");
    rd(3'd4, 32'hFF, "rst_fall");
    rd(3'd5, 32'h00, "rst_deb");
    rd(3'd7, 32'h00, "rst_addr7");
    while (sb.size() > 0) begin
      s = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== s.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", s.name, o, s.exp); end
    end
  endtask

  task automatic test_fall_edge;
    sb_t s; logic [31:0] o;
    wr(3'd2, 32'h01);
    in_port = 8'h01;
    cyc(6);
    rd(3'd3, 32'h00, "fall_no_rise_cap");
    in_port = 8'h00;
    cyc(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_irq_early: irq=%b expected 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_irq_k2: irq=%b expected 1", irq); end
    rd(3'd3, 32'h01, "fall_cap");
    wr(3'd3, 32'h01);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_w1c_irq: irq=%b expected 0", irq); end
    rd(3'd3, 32'h00, "fall_cap_cleared");
    while (sb.size() > 0) begin
      s = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== s.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", s.name, o, s.exp); end
    end
  endtask

  task automatic test_debounce;
    sb_t s; logic [31:0] o;
    wr(3'd5, 32'd4);
    wr(3'd1, 32'h08);
    wr(3'd2, 32'h08);
    in_port = 8'h08;
    cyc(3);
    in_port = 8'h00;
    cyc(10);
    rd(3'd0, 32'h00, "deb_glitch_data");
    rd(3'd3, 32'h00, "deb_glitch_cap");
    in_port = 8'h08;
    cyc(6);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL deb_irq_early: irq=%b expected 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL deb_irq_k6: irq=%b expected 1", irq); end
    rd(3'd0, 32'h08, "deb_data");
    rd(3'd3, 32'h08, "deb_cap");
    rd(3'd5, 32'h04, "deb_reg");
    wr(3'd3, 32'h08);
    rd(3'd3, 32'h00, "deb_cap_cleared");
    while (sb.size() > 0) begin
      s = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== s.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", s.name, o, s.exp); end
    end
  endtask

  task automatic test_any_edge;
    sb_t s; logic [31:0] o;
    wr(3'd1, 32'h80);
    wr(3'd4, 32'h80);
    wr(3'd2, 32'h80);
    in_port = 8'h88;
    cyc(10);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL any_rise_irq: irq=%b expected 1", irq); end
    rd(3'd3, 32'h80, "any_rise_cap");
    wr(3'd1, 32'h00);
    rd(3'd3, 32'h80, "any_cap_kept_after_en_change");
    wr(3'd3, 32'h80);
    rd(3'd3, 32'h00, "any_cap_cleared");
    in_port = 8'h08;
    cyc(10);
    rd(3'd3, 32'h80, "any_fall_cap");
    wr(3'd3, 32'h80);
    while (sb.size() > 0) begin
      s = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== s.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", s.name, o, s.exp); end
    end
  endtask

  task automatic test_back_to_back;
    sb_t s; logic [31:0] o;
    wr(3'd5, 32'd0);
    wr(3'd1, 32'h07);
    wr(3'd2, 32'h00);
    in_port = 8'h0B;
    cyc(4);
    rd(3'd3, 32'h03, "b2b_cap01");
    in_port = 8'h0F;
    cyc(2);
    wr(3'd3, 32'h04);
    rd(3'd3, 32'h07, "b2b_set_wins");
    wr(3'd3, 32'h02);
    rd(3'd3, 32'h05, "b2b_w1c_bit1");
    rd(3'd0, 32'h0F, "b2b_data");
    rd(3'd1, 32'h07, "b2b_rise");
    while (sb.size() > 0) begin
      s = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== s.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", s.name, o, s.exp); end
    end
  endtask

  task automatic test_irq_mask;
    sb_t s; logic [31:0] o;
    wr(3'd1, 32'hFF);
    wr(3'd4, 32'hFF);
    wr(3'd2, 32'h00);
    in_port = 8'hF0;
    cyc(4);
    rd(3'd3, 32'hFF, "mask_cap_all");
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_zero_irq: irq=%b expected 0", irq); end
    wr(3'd2, 32'h10);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_set_irq: irq=%b expected 1", irq); end
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h00, "mask_addr6");
    rd(3'd7, 32'h00, "mask_addr7");
    rd(3'd2, 32'h10, "mask_reg");
    rd(3'd0, 32'hF0, "mask_data");
    while (sb.size() > 0) begin
      s = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== s.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", s.name, o, s.exp); end
    end
  endtask

  task automatic test_reset_mid;
    sb_t s; logic [31:0] o;
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'hFF);
    in_port = 8'hF1;
    cyc(4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rm_irq_before: irq=%b expected 1", irq); end
    wr(3'd5, 32'd5);
    in_port = 8'hF0;
    cyc(4);
    reset = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rm_irq_reset: irq=%b expected 0", irq); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rm_readdata_reset: readdata=%h expected 0", readdata); end
    cyc(2);
    reset = 1'b0;
    rd(3'd0, 32'h00, "rm_data_r0");
    rd(3'd0, 32'h00, "rm_data_r1");
    rd(3'd0, 32'h00, "rm_data_r2");
    rd(3'd0, 32'hF0, "rm_data_r3");
    rd(3'd3, 32'h00, "rm_cap");
    rd(3'd5, 32'h00, "rm_deb");
    rd(3'd4, 32'hFF, "rm_fall");
    rd(3'd2, 32'h00, "rm_mask");
    while (sb.size() > 0) begin
      s = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== s.exp) begin errors++; $display("FAIL %s: readdata=%h expected %h", s.name, o, s.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_fall_edge();
    test_debounce();
    test_any_edge();
    test_back_to_back();
    test_irq_mask();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
